// File: rtl/axi4_slave_write_data_if.sv
// AXI4 write-address and write-data channel bundle for axi4_slave_write_data.
// The master modport drives AW/W payload and valids; the slave modport returns the readies.
interface axi4_slave_write_data_if #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  localparam int STRB = DATA_WIDTH / 8;

  logic [ID_WIDTH-1:0]   awid;
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [7:0]            awlen;
  logic [2:0]            awsize;
  logic [1:0]            awburst;
  logic                  awvalid;
  logic                  awready;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB-1:0]       wstrb;
  logic                  wlast;
  logic                  wvalid;
  logic                  wready;

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awvalid,
    output wdata, wstrb, wlast, wvalid,
    input  awready, wready
  );

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awvalid,
    input  wdata, wstrb, wlast, wvalid,
    output awready, wready
  );
endinterface

// File: rtl/axi4_slave_write_data.sv
// AXI4 slave write-address/write-data stage driving a registered memory write port.
// Define AXI4_WRAP_BURST_EN to support WRAP bursts; otherwise WRAP is addressed as INCR with SLVERR.
//
// state     | meaning
// IDLE      | awready high, waiting for an AW handshake
// DATA      | wready high, one memory write per accepted beat
// RESP_WAIT | burst reported via wdone, waiting for resp_ack
module axi4_slave_write_data #(
  parameter int ID_WIDTH   = 4,
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  axi4_slave_write_data_if.slave  bus,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_wstrb,
  output logic                    wdone,
  output logic [ID_WIDTH-1:0]     stored_awid,
  output logic                    burst_err,
  input  logic                    resp_ack
);
  localparam int STRB     = DATA_WIDTH / 8;
  localparam int SIZE_MAX = $clog2(STRB);

  typedef enum logic [1:0] {IDLE, DATA, RESP_WAIT} state_t;

  state_t                state;
  logic [7:0]            beat_cnt;
  logic [7:0]            len;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] size_bytes;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic                  fixed;
  logic                  wrap_en;
  logic                  cfg_err;
  logic                  suppress;

  logic                  aw_size_bad;
  logic                  aw_reserved;
  logic                  aw_wrap_en;
  logic                  aw_wrap_err;
  logic [ADDR_WIDTH-1:0] aw_size_bytes;
  logic [ADDR_WIDTH-1:0] aw_wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic                  last_by_cnt;

  assign aw_size_bad   = bus.awsize > 3'(SIZE_MAX);
  assign aw_reserved   = bus.awburst == 2'b11;
  assign aw_size_bytes = ADDR_WIDTH'(1) << bus.awsize;
  assign aw_wrap_mask  = ((ADDR_WIDTH'(bus.awlen) + ADDR_WIDTH'(1)) << bus.awsize) - ADDR_WIDTH'(1);

`ifdef AXI4_WRAP_BURST_EN
  logic aw_len_ok;
  logic aw_aligned;
  assign aw_len_ok   = (bus.awlen == 8'd1) || (bus.awlen == 8'd3) ||
                       (bus.awlen == 8'd7) || (bus.awlen == 8'd15);
  assign aw_aligned  = (bus.awaddr & (aw_size_bytes - ADDR_WIDTH'(1))) == '0;
  assign aw_wrap_en  = (bus.awburst == 2'b10) && aw_len_ok && aw_aligned;
  assign aw_wrap_err = (bus.awburst == 2'b10) && !(aw_len_ok && aw_aligned);
`else
  assign aw_wrap_en  = 1'b0;
  assign aw_wrap_err = bus.awburst == 2'b10;
`endif

  // Wrap keeps the boundary base from the current address and wraps only the offset bits.
  assign incr_addr   = cur_addr + size_bytes;
  assign next_addr   = fixed   ? cur_addr :
                       wrap_en ? ((cur_addr & ~wrap_mask) | (incr_addr & wrap_mask)) :
                                 incr_addr;
  assign last_by_cnt = beat_cnt == len;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      bus.awready <= 1'b0;
      bus.wready  <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      mem_wstrb   <= '0;
      wdone       <= 1'b0;
      stored_awid <= '0;
      burst_err   <= 1'b0;
      beat_cnt    <= '0;
      len         <= '0;
      cur_addr    <= '0;
      size_bytes  <= '0;
      wrap_mask   <= '0;
      fixed       <= 1'b0;
      wrap_en     <= 1'b0;
      cfg_err     <= 1'b0;
      suppress    <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      wdone  <= 1'b0;
      case (state)
        IDLE: begin
          bus.awready <= 1'b1;
          bus.wready  <= 1'b0;
          if (bus.awvalid && bus.awready) begin
            stored_awid <= bus.awid;
            len         <= bus.awlen;
            cur_addr    <= bus.awaddr;
            size_bytes  <= aw_size_bytes;
            wrap_mask   <= aw_wrap_mask;
            fixed       <= bus.awburst == 2'b00;
            wrap_en     <= aw_wrap_en;
            cfg_err     <= aw_reserved || aw_size_bad || aw_wrap_err;
            suppress    <= aw_reserved || aw_size_bad;
            beat_cnt    <= '0;
            bus.awready <= 1'b0;
            bus.wready  <= 1'b1;
            state       <= DATA;
          end
        end
        DATA: begin
          if (bus.wvalid && bus.wready) begin
            mem_we    <= !suppress;
            mem_addr  <= cur_addr;
            mem_wdata <= bus.wdata;
            mem_wstrb <= bus.wstrb;
            beat_cnt  <= beat_cnt + 8'd1;
            cur_addr  <= next_addr;
            if (bus.wlast || last_by_cnt) begin
              // wlast and the beat count must agree, otherwise the burst was early or short.
              burst_err  <= cfg_err || (bus.wlast != last_by_cnt);
              wdone      <= 1'b1;
              bus.wready <= 1'b0;
              state      <= RESP_WAIT;
            end
          end
        end
        RESP_WAIT: begin
          if (resp_ack) begin
            bus.awready <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          bus.awready <= 1'b0;
          bus.wready  <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end
endmodule
